// File: rtl/sram16_pkg.sv
// sram16_pkg
// Shared types and constants for the 32-bit to 16-bit asynchronous SRAM
// bridge: the sequencer state enum, the half-select encoding, the bundle of
// active-low strobes with its all-inactive value, and small helpers that pick
// one half of a word or of the byte-enable vector.
// Optional feature macro used by the bridge: SRAM16_MISALIGN_TRAP_EN.

package sram16_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP_HI = 3'd1,
    ACC_HI   = 3'd2,
    SETUP_LO = 3'd3,
    ACC_LO   = 3'd4,
    RESP     = 3'd5
  } state_e;

  // Half-select encoding: the high half is always transferred first.
  localparam logic HALF_HI = 1'b1;
  localparam logic HALF_LO = 1'b0;

  // All SRAM control strobes, active low.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } strobe_t;

  localparam strobe_t STROBE_INACTIVE = strobe_t'(5'b11111);

  // Returns the 16-bit half of a 32-bit word selected by 'half'.
  function automatic logic [15:0] half_data(input logic [31:0] word, input logic half);
    return (half == HALF_HI) ? word[31:16] : word[15:0];
  endfunction

  // Returns the byte-enable pair {upper byte, lower byte} for one half.
  function automatic logic [1:0] half_be(input logic [3:0] be, input logic half);
    return (half == HALF_HI) ? be[3:2] : be[1:0];
  endfunction

endpackage

// File: rtl/sram16_wait_ctr.sv
// sram16_wait_ctr
// Loadable down-counter that times the access phase of one SRAM half cycle.
// Loading sets the count to WAIT_CYCLES-1; it then decrements once per cycle
// while dec_i is high and holds at zero. done_o is high whenever the count is
// zero, i.e. on the last access cycle.
// Ports:
//   clk     system clock
//   reset   synchronous, active-high reset (count cleared to zero)
//   load_i  load WAIT_CYCLES-1 (takes priority over dec_i)
//   dec_i   decrement while non-zero
//   done_o  count is zero

module sram16_wait_ctr
  import sram16_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load on entry to an access phase, otherwise count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram16_bridge.sv
// sram16_bridge
// Memory-side stage between the CPU's 32-bit load/store port and a 16-bit
// asynchronous SRAM. Each accepted request becomes up to two SRAM cycles,
// high half first, each made of one SETUP cycle and WAIT_CYCLES access
// cycles, followed by a single RESP cycle carrying rsp_valid.
// All SRAM-facing signals and response outputs are registered: the next state
// is decoded into next-cycle output values which are then flopped, so the
// strobes never glitch.
// Optional feature: define SRAM16_MISALIGN_TRAP_EN to answer requests whose
// req_addr[1:0] is non-zero with rsp_err=1 and no SRAM cycle. Without it the
// low address bits are ignored and rsp_err is constant 0.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we/addr/wdata/be       request fields, captured at acceptance
//   rsp_valid/rdata/err        one-cycle response, read data {hi,lo}, error
//   sram_addr                  SRAM halfword address
//   sram_dq_o/oe/i             split data bus for the top-level tri-state pad
//   sram_ce_n/oe_n/we_n/ub_n/lb_n  active-low SRAM strobes

module sram16_bridge
  import sram16_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  state_e state_q, state_d;

  // Request fields captured at acceptance.
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] base_q;

  // Registered outputs.
  strobe_t           strobe_q, strobe_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       sram_dq_o_q, sram_dq_o_d;
  logic              sram_dq_oe_q, sram_dq_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       rd_hi_q;

  logic              accept;
  logic              misalign;
  logic              ctr_load, ctr_dec, ctr_done;

  // Fields seen by the output decoder: on the acceptance edge the capture
  // registers are not loaded yet, so the live request is used instead.
  logic              cur_we;
  logic [3:0]        cur_be;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] req_base;

  logic              cur_half;
  logic              in_setup, in_acc;
  logic              unused_addr_bits;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef SRAM16_MISALIGN_TRAP_EN
  assign misalign = (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Bits outside the halfword window (and the byte offset) carry no meaning.
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

  assign req_base  = {req_addr[ADDR_W:2], 1'b0};
  assign cur_we    = accept ? req_we    : we_q;
  assign cur_be    = accept ? req_be    : be_q;
  assign cur_wdata = accept ? req_wdata : wdata_q;
  assign cur_base  = accept ? req_base  : base_q;

  // The wait counter is loaded while in SETUP so it holds WAIT_CYCLES-1 on the
  // first access cycle, and counts down through the access phase.
  assign ctr_load = (state_q == SETUP_HI) || (state_q == SETUP_LO);
  assign ctr_dec  = (state_q == ACC_HI)   || (state_q == ACC_LO);

  sram16_wait_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctr (
    .clk    (clk),
    .reset  (reset),
    .load_i (ctr_load),
    .dec_i  (ctr_dec),
    .done_o (ctr_done)
  );

  // Sequencer next state. A write half whose byte-enable pair is zero is
  // skipped entirely; a misaligned trap or an all-zero write goes straight
  // to RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            state_d = RESP;
          end else if (req_we && (req_be[3:2] == 2'b00)) begin
            state_d = (req_be[1:0] == 2'b00) ? RESP : SETUP_LO;
          end else begin
            state_d = SETUP_HI;
          end
        end
      end
      SETUP_HI: state_d = ACC_HI;
      ACC_HI: begin
        if (ctr_done) begin
          state_d = (we_q && (be_q[1:0] == 2'b00)) ? RESP : SETUP_LO;
        end
      end
      SETUP_LO: state_d = ACC_LO;
      ACC_LO: begin
        if (ctr_done) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cur_half = ((state_d == SETUP_HI) || (state_d == ACC_HI)) ? HALF_HI : HALF_LO;
  assign in_setup = (state_d == SETUP_HI) || (state_d == SETUP_LO);
  assign in_acc   = (state_d == ACC_HI)   || (state_d == ACC_LO);

  // Output decode for the cycle being entered. Address and write data are
  // already valid in SETUP, and only the access cycles pulse oe_n or we_n, so
  // the address never moves while we_n is low. Write data and address hold
  // their last values outside a transfer.
  always_comb begin
    strobe_d     = STROBE_INACTIVE;
    sram_addr_d  = sram_addr_q;
    sram_dq_o_d  = sram_dq_o_q;
    sram_dq_oe_d = 1'b0;
    if (in_setup || in_acc) begin
      strobe_d.ce_n = 1'b0;
      sram_addr_d   = (cur_half == HALF_HI) ? cur_base : {cur_base[ADDR_W-1:1], 1'b1};
      if (cur_we) begin
        sram_dq_oe_d = 1'b1;
        sram_dq_o_d  = half_data(cur_wdata, cur_half);
      end
    end
    if (in_acc) begin
      if (cur_we) begin
        strobe_d.we_n                 = 1'b0;
        {strobe_d.ub_n, strobe_d.lb_n} = ~half_be(cur_be, cur_half);
      end else begin
        strobe_d.oe_n = 1'b0;
        strobe_d.ub_n = 1'b0;
        strobe_d.lb_n = 1'b0;
      end
    end
  end

  assign rsp_valid_d = (state_d == RESP);
  assign rsp_err_d   = accept && misalign;

  // State, captured request and registered outputs. Reset drops any
  // transaction in flight and returns every strobe to inactive on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      base_q       <= '0;
      strobe_q     <= STROBE_INACTIVE;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      sram_addr_q  <= sram_addr_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      if (accept) begin
        we_q    <= req_we;
        be_q    <= req_be;
        wdata_q <= req_wdata;
        base_q  <= req_base;
      end
    end
  end

  // Read capture on the last access cycle of each half. The high half is
  // parked in rd_hi_q so rsp_rdata only changes when a full read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hi_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if ((state_q == ACC_HI) && ctr_done && !we_q) begin
        rd_hi_q <= sram_dq_i;
      end
      if ((state_q == ACC_LO) && ctr_done && !we_q) begin
        rsp_rdata_q <= {rd_hi_q, sram_dq_i};
      end
    end
  end

  assign sram_ce_n  = strobe_q.ce_n;
  assign sram_oe_n  = strobe_q.oe_n;
  assign sram_we_n  = strobe_q.we_n;
  assign sram_ub_n  = strobe_q.ub_n;
  assign sram_lb_n  = strobe_q.lb_n;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_sram16_bridge.sv
// tb_sram16_bridge
// Testbench for sram16_bridge. A behavioural SRAM device answers the bridge's
// strobes; a separate reference memory is updated from the request-level
// rules (word address, byte enables, high half first) and is used to predict
// read data, latency and the final memory image.
// Honours SRAM16_MISALIGN_TRAP_EN the same way the design does.

module tb_sram16_bridge;

  localparam int ADDR_W   = 20;
  localparam int W        = 1;
  localparam int FULL_LAT = 2 * (W + 1) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_i = '0;
  logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  sram16_bridge #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;
  int busErr    = 0;

  logic [15:0] devMem [int];
  logic [15:0] refMem [int];

  function automatic logic [15:0] devRd(input int a);
    return devMem.exists(a) ? devMem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] refRd(input int a);
    return refMem.exists(a) ? refMem[a] : 16'h0000;
  endfunction

  // Reference model: halfword base of a byte address inside the 2^20 window.
  function automatic int hwBase(input logic [31:0] addr);
    return int'((addr >> 2) & 32'h0007_FFFF) * 2;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] addr);
    return {refRd(hwBase(addr)), refRd(hwBase(addr) + 1)};
  endfunction

  task automatic refWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int hw;
    logic [15:0] hi, lo;
    hw = hwBase(addr);
    hi = refRd(hw);
    lo = refRd(hw + 1);
    if (be[3]) hi[15:8] = wdata[31:24];
    if (be[2]) hi[7:0]  = wdata[23:16];
    if (be[1]) lo[15:8] = wdata[15:8];
    if (be[0]) lo[7:0]  = wdata[7:0];
    refMem[hw]     = hi;
    refMem[hw + 1] = lo;
  endtask

  function automatic bit isTrap(input logic [31:0] addr);
`ifdef SRAM16_MISALIGN_TRAP_EN
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles from acceptance to response: one per SETUP plus W per access for
  // every half transferred, plus the RESP cycle.
  function automatic int expLat(input logic we, input logic [31:0] addr, input logic [3:0] be);
    int halves;
    if (isTrap(addr)) return 1;
    halves = we ? (int'(be[3:2] != 2'b00) + int'(be[1:0] != 2'b00)) : 2;
    return 1 + halves * (W + 1);
  endfunction

  // SRAM device model and bus-safety watch, evaluated mid-cycle.
  logic [ADDR_W-1:0] prevAddr = '0;
  always @(negedge clk) begin
    int a;
    logic [15:0] v;
    a = int'(sram_addr);
    if (!sram_oe_n && sram_dq_oe) busErr++;
    if (!sram_oe_n && !sram_we_n) busErr++;
    if (!sram_we_n && (sram_addr != prevAddr)) busErr++;
    if (!sram_ce_n && !sram_we_n) begin
      v = devRd(a);
      if (!sram_ub_n) v[15:8] = sram_dq_o[15:8];
      if (!sram_lb_n) v[7:0]  = sram_dq_o[7:0];
      devMem[a] = v;
    end
    if (!sram_ce_n && !sram_oe_n) sram_dq_i = devRd(a);
    else                          sram_dq_i = 16'($urandom);
    prevAddr = sram_addr;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Results of the last transaction.
  int          lat;
  logic [31:0] rspData;
  logic        rspErr;
  int          accAddr[$];
  logic [15:0] accData[$];
  logic [1:0]  accLanes[$];
  int          oeLow;
  int          ceLow;

  // Issues one request, then follows it cycle by cycle up to its response.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int guard;
    guard = 0;
    while (!req_ready && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    accAddr.delete();
    accData.delete();
    accLanes.delete();
    oeLow = 0;
    ceLow = 0;
    lat   = 1;
    while (1) begin
      if (!sram_ce_n) ceLow++;
      if (!sram_oe_n) begin
        oeLow++;
        accAddr.push_back(int'(sram_addr));
      end
      if (!sram_we_n) begin
        accAddr.push_back(int'(sram_addr));
        accData.push_back(sram_dq_o);
        accLanes.push_back({sram_ub_n, sram_lb_n});
      end
      if (rsp_valid || lat >= 30) break;
      @(posedge clk); #1;
      lat++;
    end
    rspData = rsp_rdata;
    rspErr  = rsp_err;
  endtask

  initial begin
    logic [31:0] lastRead;
    logic [31:0] exp32;
    logic [31:0] a32;
    logic [31:0] d32;
    logic [3:0]  be4;
    logic        we1;
    logic [15:0] v16;
    int          acc[$];
    int          rsp[$];
    logic [31:0] got[$];
    int          readyInResp;
    int          extra;
    int          bad;

    lastRead = '0;
    for (int a = 0; a < 130; a++) begin
      v16 = 16'($urandom);
      devMem[a] = v16;
      refMem[a] = v16;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReady",  32'(req_ready), 32'h1);
    checkOutput("rstRspVal", 32'(rsp_valid), 32'h0);
    checkOutput("rstRdata",  rsp_rdata, 32'h0);
    checkOutput("rstErr",    32'(rsp_err), 32'h0);
    checkOutput("rstAddr",   32'(sram_addr), 32'h0);
    checkOutput("rstDqO",    32'(sram_dq_o), 32'h0);
    checkOutput("rstDqOe",   32'(sram_dq_oe), 32'h0);
    checkOutput("rstStrobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("idleReady", 32'(req_ready), 32'h1);

    // Directed read at 0x10.
    devMem[8] = 16'hDEAD; refMem[8] = 16'hDEAD;
    devMem[9] = 16'hBEEF; refMem[9] = 16'hBEEF;
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    checkOutput("rdLat",   32'(lat), 32'(FULL_LAT));
    checkOutput("rdData",  rspData, 32'hDEAD_BEEF);
    checkOutput("rdNAcc",  32'(accAddr.size()), 32'd2);
    checkOutput("rdAddrHi", 32'((accAddr.size() > 0) ? accAddr[0] : -1), 32'h8);
    checkOutput("rdAddrLo", 32'((accAddr.size() > 1) ? accAddr[1] : -1), 32'h9);
    checkOutput("rdErr",   32'(rspErr), 32'h0);
    lastRead = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checkOutput("rspPulse", 32'(rsp_valid), 32'h0);
    checkOutput("rspReadyAfter", 32'(req_ready), 32'h1);

    // Directed full write at 0x20.
    applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
    refWrite(32'h0000_0020, 32'h1234_5678, 4'hF);
    checkOutput("wrLat",    32'(lat), 32'(FULL_LAT));
    checkOutput("wrOeLow",  32'(oeLow), 32'h0);
    checkOutput("wrNAcc",   32'(accAddr.size()), 32'd2);
    checkOutput("wrAddrHi", 32'((accAddr.size() > 0) ? accAddr[0] : -1), 32'h10);
    checkOutput("wrAddrLo", 32'((accAddr.size() > 1) ? accAddr[1] : -1), 32'h11);
    checkOutput("wrDataHi", 32'((accData.size() > 0) ? accData[0] : 16'h0), 32'h1234);
    checkOutput("wrDataLo", 32'((accData.size() > 1) ? accData[1] : 16'h0), 32'h5678);
    checkOutput("wrKeepsRdata", rspData, lastRead);

    // Low byte only: the high half is skipped.
    applyStimulus(1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0001);
    refWrite(32'h0000_0040, 32'hAABB_CCDD, 4'b0001);
    checkOutput("skipLat",   32'(lat), 32'd3);
    checkOutput("skipNAcc",  32'(accAddr.size()), 32'd1);
    checkOutput("skipAddr",  32'((accAddr.size() > 0) ? accAddr[0] : -1), 32'h21);
    checkOutput("skipLanes", 32'((accLanes.size() > 0) ? accLanes[0] : 2'b00), 32'b10);
    checkOutput("skipMem",   32'(devRd(32'h21)), 32'(refRd(32'h21)));

    // All byte enables clear: straight to the response.
    applyStimulus(1'b1, 32'h0000_0044, 32'h1111_2222, 4'b0000);
    checkOutput("noBeLat",  32'(lat), 32'd1);
    checkOutput("noBeCe",   32'(ceLow), 32'd0);

    // Back-to-back reads with req_valid held high.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0030; req_be = 4'hF;
    readyInResp = -1;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) acc.push_back(c);
      if (rsp_valid) begin
        rsp.push_back(c);
        got.push_back(rsp_rdata);
      end
      if (c == 5) readyInResp = int'(req_ready);
      @(posedge clk); #1;
      if (c == 6) req_valid = 1'b0;
    end
    checkOutput("b2bNAcc",    32'(acc.size()), 32'd2);
    checkOutput("b2bAcc2",    32'((acc.size() > 1) ? acc[1] : -1), 32'(FULL_LAT + 1));
    checkOutput("b2bNRsp",    32'(rsp.size()), 32'd2);
    checkOutput("b2bRsp1",    32'((rsp.size() > 0) ? rsp[0] : -1), 32'(FULL_LAT));
    checkOutput("b2bRsp2",    32'((rsp.size() > 1) ? rsp[1] : -1), 32'(2 * FULL_LAT + 1));
    checkOutput("b2bNotReadyInResp", 32'(readyInResp), 32'd0);
    checkOutput("b2bData",    (got.size() > 1) ? got[1] : 32'hX, refRead(32'h0000_0030));
    lastRead = refRead(32'h0000_0030);

    // Reset asserted during ACC_HI of a write.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_03F8;
    req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("abtWeLow", 32'(sram_we_n), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abtWeN",   32'(sram_we_n), 32'h1);
    checkOutput("abtCeN",   32'(sram_ce_n), 32'h1);
    checkOutput("abtDqOe",  32'(sram_dq_oe), 32'h0);
    checkOutput("abtReady", 32'(req_ready), 32'h1);
    checkOutput("abtRspV",  32'(rsp_valid), 32'h0);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
    end
    checkOutput("abtNoRsp", 32'(extra), 32'd0);
    applyStimulus(1'b0, 32'h0000_03F8, 32'h0, 4'hF);
    checkOutput("abtReadBack", rspData, 32'hCAFE_0000);
    lastRead = 32'hCAFE_0000;

    // Misaligned read at 0x02.
    applyStimulus(1'b0, 32'h0000_0002, 32'h0, 4'hF);
`ifdef SRAM16_MISALIGN_TRAP_EN
    checkOutput("misLat",   32'(lat), 32'd1);
    checkOutput("misErr",   32'(rspErr), 32'h1);
    checkOutput("misCe",    32'(ceLow), 32'd0);
    checkOutput("misRdata", rspData, lastRead);
`else
    checkOutput("misLat",    32'(lat), 32'(FULL_LAT));
    checkOutput("misErr",    32'(rspErr), 32'h0);
    checkOutput("misAddrHi", 32'((accAddr.size() > 0) ? accAddr[0] : -1), 32'h0);
    checkOutput("misAddrLo", 32'((accAddr.size() > 1) ? accAddr[1] : -1), 32'h1);
    checkOutput("misRdata",  rspData, refRead(32'h0000_0000));
    lastRead = refRead(32'h0000_0000);
`endif

    // Random traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      we1 = 1'($urandom);
      be4 = 4'($urandom);
      d32 = $urandom;
      a32 = ($urandom & 32'hFFE0_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(we1, a32, d32, be4);
      checkOutput("rndLat", 32'(lat), 32'(expLat(we1, a32, be4)));
      checkOutput("rndErr", 32'(rspErr), 32'(isTrap(a32)));
      if (isTrap(a32) || we1) begin
        if (!isTrap(a32)) refWrite(a32, d32, be4);
        checkOutput("rndKeepRdata", rspData, lastRead);
      end else begin
        exp32 = refRead(a32);
        checkOutput("rndRead", rspData, exp32);
        lastRead = exp32;
      end
    end

    bad = 0;
    for (int a = 0; a < 130; a++) begin
      if (devRd(a) !== refRd(a)) bad++;
    end
    checkOutput("memImage", 32'(bad), 32'd0);
    checkOutput("busSafety", 32'(busErr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
